bpsk_symbol_sched: RTL
======================

Name: bpsk_symbol_sched

Overview:
Frame-level sequencer for the BPSK modulator chain. It accepts payload bytes on an AXI-Stream slave and drives the phase generator's gen_en and phase_ctrl inputs, one bit per symbol. Each frame is sent as a fixed preamble, then the payload bits MSB-first, then a silent guard gap. It sits between the DMA/packet source and the phase generator feeding the DDS sine LUT.

Parameters:
SYMBOL_CYCLES, 50, clocks per BPSK symbol (>=2)
PREAMBLE_BITS, 16, preamble length in symbols (1..32)
PREAMBLE_PATTERN, 32'h0000AAAA, preamble bits, low PREAMBLE_BITS used, sent MSB (bit PREAMBLE_BITS-1) first
GAP_CYCLES, 32, clocks of gen_en=0 after each frame (>=1)

Ports:
aclk  in  1  clock
arst  in  1  asynchronous active-high reset
s_axis_tdata  in  8  payload byte
s_axis_tvalid  in  1  byte valid
s_axis_tlast  in  1  byte is last of frame
s_axis_tready  out  1  holding register empty
gen_en  out  1  phase generator enable
phase_ctrl  out  1  0 = 0 deg, 1 = 180 deg
busy  out  1  state != IDLE
frame_done  out  1  1-cycle pulse, frame ended normally
underrun  out  1  1-cycle pulse, frame aborted for missing byte

Behaviour:
- Reset (async, arst=1): state IDLE; gen_en, phase_ctrl, busy, frame_done, underrun = 0. Holding register is emptied, so s_axis_tready = 0 during reset and 1 on the first cycle after. Counters are 0. A mid-frame reset takes effect immediately, and the partial frame is discarded.
- All outputs are registered except s_axis_tready, which equals !hold_valid and is not gated by state.
- Holding register: one byte plus its last flag. It fills on the handshake tvalid&tready and empties when DATA loads it into the shift register. A load and a new handshake never occur in the same cycle, because tready is 0 while the register is full.
- Symbol timing: a cycle counter runs 0..SYMBOL_CYCLES-1. The symbol boundary is at count = SYMBOL_CYCLES-1. phase_ctrl changes only at boundaries, so every symbol lasts exactly SYMBOL_CYCLES clocks.
- FSM:
  - IDLE: gen_en=0, phase_ctrl=0. When hold_valid=1, go to PREAMBLE on the next edge; gen_en=1 and phase_ctrl=PREAMBLE_PATTERN[PREAMBLE_BITS-1] take effect on that same edge. A handshake at edge T therefore gives gen_en=1 after edge T+1.
  - PREAMBLE: sends PREAMBLE_BITS symbols. At the final preamble boundary, go to DATA, load the shift register from the holding register, and output bit 7 of that byte. The first byte is guaranteed present.
  - DATA: bit counter 7..0. At each boundary, shift out the next bit. At the boundary ending bit 0:
    - current byte had last=1: go to GAP, pulse frame_done.
    - else if hold_valid=1: load the next byte, output its bit 7, stay in DATA. Byte boundaries have no gap or extra cycle.
    - else: go to GAP and pulse underrun. The frame is aborted; later bytes form a new frame.
  - GAP: gen_en=0, phase_ctrl=0 for GAP_CYCLES clocks, then IDLE. A byte may be accepted into the holding register during GAP, but the next frame starts only from IDLE.
- frame_done/underrun assert on the edge that enters GAP, for one cycle. They never assert together.
- busy=1 in PREAMBLE, DATA, GAP.
- Counter widths use $clog2 of the respective parameter, minimum 1 bit. Counters wrap only by explicit reload; overflow must not be possible.

Test Plan:
(Overrides: SYMBOL_CYCLES=4, PREAMBLE_BITS=4, PREAMBLE_PATTERN=4'hA, GAP_CYCLES=8.)
1. Reset, then send single byte 8'hC5 with tlast=1 at edge T -> gen_en=1 from T+1 to T+1+48 cycles. phase_ctrl sequence per 4-cycle symbol is 1,0,1,0, 1,1,0,0,0,1,0,1. frame_done pulses at gen_en fall. gen_en stays low 8 cycles, then busy=0.
2. Three bytes 8'hFF, 8'h00, 8'h81 (last on third) presented back-to-back -> continuous gen_en for 4+24 symbols. phase_ctrl is 1x8, 0x8, then 1,0,0,0,0,0,0,1. No idle cycle at byte boundaries; s_axis_tready drops while full and reasserts on the cycle after each load.
3. Two bytes without tlast, then tvalid=0 -> underrun pulses after the 2nd byte's bit 0. frame_done stays 0; GAP 8 cycles; IDLE.
4. Assert arst for one cycle mid-DATA -> gen_en, phase_ctrl, busy = 0 immediately (same cycle, async). tready=0 during reset, 1 afterwards. A new byte starts a fresh preamble.
5. Byte presented during GAP of previous frame -> accepted (tready=1). The new preamble starts exactly one cycle after the GAP->IDLE transition, so the gap is never shortened below 8 cycles.
6. Hold tvalid=0 for 100 cycles after reset -> gen_en=0, busy=0, no pulses, tready=1 throughout.

Source files
------------

// File: rtl/bpsk_symbol_sched_if.sv
// Payload byte stream from the packet source into the BPSK symbol scheduler.
// The slave side's tready means its one-byte holding register is empty.
interface bpsk_symbol_sched_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bpsk_symbol_sched.sv
// Frame sequencer for the BPSK phase generator. Each frame is a fixed preamble,
// then the payload bits MSB-first, then a silent guard gap.
//
// state    | meaning
// IDLE     | generator off; waits for a byte in the holding register
// PREAMBLE | sends the PREAMBLE_BITS preamble symbols
// DATA     | shifts payload bits out; chains bytes with no gap between them
// GAP      | generator off for GAP_CYCLES clocks, then returns to IDLE
module bpsk_symbol_sched #(
  parameter int          SYMBOL_CYCLES    = 50,
  parameter int          PREAMBLE_BITS    = 16,
  parameter logic [31:0] PREAMBLE_PATTERN = 32'h0000AAAA,
  parameter int          GAP_CYCLES       = 32
) (
  input  logic         aclk,
  input  logic         arst,
  bpsk_symbol_sched_if.slave s_axis,
  output logic         gen_en,
  output logic         phase_ctrl,
  output logic         busy,
  output logic         frame_done,
  output logic         underrun
);

  localparam int SW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int PW = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
  localparam int GW = (GAP_CYCLES > 1)    ? $clog2(GAP_CYCLES)    : 1;

  localparam logic [SW-1:0] SYM_LAST = SW'(SYMBOL_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  // Preamble left-justified so its first symbol is always bit 31.
  localparam logic [31:0] PRE_ALIGNED = PREAMBLE_PATTERN << (32 - PREAMBLE_BITS);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

  state_t        state_q;
  logic [SW-1:0] sym_cnt_q;
  logic [PW-1:0] pre_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [30:0]   pre_sh_q;
  logic [6:0]    shift_q;
  logic          last_q;
  logic [7:0]    hold_q;
  logic          hold_last_q;
  logic          hold_valid_q;
  logic          gen_en_q;
  logic          phase_q;
  logic          busy_q;
  logic          frame_done_q;
  logic          underrun_q;
  logic          sym_end;

  assign sym_end       = (sym_cnt_q == SYM_LAST);
  assign s_axis.tready = !hold_valid_q && !arst;

  assign gen_en     = gen_en_q;
  assign phase_ctrl = phase_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      sym_cnt_q    <= '0;
      pre_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      pre_sh_q     <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      gen_en_q     <= 1'b0;
      phase_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;

      // A load below only happens while the register is full, so it never
      // collides with this fill.
      if (s_axis.tvalid && !hold_valid_q) begin
        hold_q       <= s_axis.tdata;
        hold_last_q  <= s_axis.tlast;
        hold_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (hold_valid_q) begin
            state_q   <= PREAMBLE;
            busy_q    <= 1'b1;
            gen_en_q  <= 1'b1;
            phase_q   <= PRE_ALIGNED[31];
            pre_sh_q  <= PRE_ALIGNED[30:0];
            pre_cnt_q <= '0;
            sym_cnt_q <= '0;
          end
        end

        PREAMBLE: begin
          if (sym_end) begin
            sym_cnt_q <= '0;
            if (pre_cnt_q == PRE_LAST) begin
              state_q      <= DATA;
              shift_q      <= hold_q[6:0];
              phase_q      <= hold_q[7];
              last_q       <= hold_last_q;
              hold_valid_q <= 1'b0;
              bit_cnt_q    <= 3'd7;
            end else begin
              pre_cnt_q <= pre_cnt_q + PW'(1);
              phase_q   <= pre_sh_q[30];
              pre_sh_q  <= {pre_sh_q[29:0], 1'b0};
            end
          end else begin
            sym_cnt_q <= sym_cnt_q + SW'(1);
          end
        end

        DATA: begin
          if (sym_end) begin
            sym_cnt_q <= '0;
            if (bit_cnt_q != 3'd0) begin
              bit_cnt_q <= bit_cnt_q - 3'd1;
              phase_q   <= shift_q[6];
              shift_q   <= {shift_q[5:0], 1'b0};
            end else if (!last_q && hold_valid_q) begin
              shift_q      <= hold_q[6:0];
              phase_q      <= hold_q[7];
              last_q       <= hold_last_q;
              hold_valid_q <= 1'b0;
              bit_cnt_q    <= 3'd7;
            end else begin
              // Either a clean end of frame or a starved stream; both go quiet.
              state_q      <= GAP;
              gen_en_q     <= 1'b0;
              phase_q      <= 1'b0;
              gap_cnt_q    <= '0;
              frame_done_q <= last_q;
              underrun_q   <= !last_q;
            end
          end else begin
            sym_cnt_q <= sym_cnt_q + SW'(1);
          end
        end

        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end

        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          gen_en_q <= 1'b0;
          phase_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
